// File: rtl/special_reg_wr_arbiter.sv
// special_reg_wr_arbiter
// Round-robin arbiter sharing the special register file's single write port
// among NUM_REQ requesters. Grants are combinational; the write strobe,
// address and data toward the register file are registered, so a grant in
// cycle T is written by the file at the end of T+1.
// Optional feature macro: SRF_ARB_LOCK_EN adds the LOCKED state so that one
// requester can keep ownership across an atomic multi-register sequence.
module special_reg_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [3*NUM_REQ-1:0]      req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wr_hold,
    output logic                      wr_enable,
    output logic [2:0]                write_addr,
    output logic [DATA_W-1:0]         usr_data,
    output logic [2:0]                owner,
    output logic                      locked
);

    // Search start for the next round-robin pass.
    logic [2:0]        rr_ptr;
    logic              grant_any;
    logic [2:0]        grant_idx;
    logic [2:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_lock;
    logic [2:0]        rr_ptr_next;

`ifdef SRF_ARB_LOCK_EN
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
    state_t state;
`else
    // Lock requests carry no meaning without the lock feature.
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Pick the requester to grant this cycle (round-robin, or owner-only when locked).
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = 3'd0;
        idx       = 0;
        if (!wr_hold) begin
`ifdef SRF_ARB_LOCK_EN
            if (state == LOCKED) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (3'(i) == owner && req_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = 3'(i);
                    end
                end
            end else
`endif
            begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NUM_REQ) begin
                        idx = idx - NUM_REQ;
                    end
                    if (!grant_any && req_valid[idx]) begin
                        grant_any = 1'b1;
                        grant_idx = 3'(idx);
                    end
                end
            end
        end
    end

    // One-hot grant, suppressed while reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_any && !rst && (grant_idx == 3'(gi));
        end
    endgenerate

    // Route the granted requester's fields toward the output registers.
    always_comb begin
        sel_addr = 3'd0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_addr = req_addr[3*i +: 3];
                sel_data = req_data[DATA_W*i +: DATA_W];
                sel_lock = req_lock[i];
            end
        end
        rr_ptr_next = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
    end

    // Register the write toward the file and advance arbitration state on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable  <= 1'b0;
            write_addr <= 3'd0;
            usr_data   <= '0;
            owner      <= 3'd0;
            rr_ptr     <= 3'd0;
            locked     <= 1'b0;
`ifdef SRF_ARB_LOCK_EN
            state      <= ARB;
`endif
        end else begin
            wr_enable <= 1'b0;
            if (grant_any) begin
                // ZR writes consume the slot but never strobe the file.
                wr_enable  <= (sel_addr != 3'd0);
                write_addr <= sel_addr;
                usr_data   <= sel_data;
                owner      <= grant_idx;
                rr_ptr     <= rr_ptr_next;
`ifdef SRF_ARB_LOCK_EN
                if (state == ARB && sel_lock) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end else if (state == LOCKED && !sel_lock) begin
                    state  <= ARB;
                    locked <= 1'b0;
                end
`else
                locked <= 1'b0;
`endif
            end
        end
    end

`ifndef SRF_ARB_LOCK_EN
    logic unused_sel_lock;
    assign unused_sel_lock = sel_lock;
`endif

endmodule

// File: tb/tb_special_reg_wr_arbiter.sv
// Directed testbench for special_reg_wr_arbiter (NUM_REQ=4, DATA_W=32).
// The lock scenario is exercised only when SRF_ARB_LOCK_EN is defined.
module tb_special_reg_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [3*NUM_REQ-1:0]      req_addr;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wr_hold;
    logic                      wr_enable;
    logic [2:0]                write_addr;
    logic [DATA_W-1:0]         usr_data;
    logic [2:0]                owner;
    logic                      locked;

    int checks = 0;
    int fails  = 0;

    special_reg_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
        .wr_hold(wr_hold), .wr_enable(wr_enable), .write_addr(write_addr),
        .usr_data(usr_data), .owner(owner), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] a,
                           input logic [31:0] d, input logic l);
        req_valid[i]          = v;
        req_addr[3*i +: 3]    = a;
        req_data[32*i +: 32]  = d;
        req_lock[i]           = l;
    endtask

    // Check the write registered on the previous edge.
    task automatic check_wr(input string tag, input logic en, input logic [2:0] a,
                            input logic [31:0] d, input logic [2:0] o);
        check({tag, "_en"},   64'(wr_enable),  64'(en));
        check({tag, "_addr"}, 64'(write_addr), 64'(a));
        check({tag, "_data"}, 64'(usr_data),   64'(d));
        check({tag, "_own"},  64'(owner),      64'(o));
    endtask

    initial begin
        logic [3:0] exp_g;
        int         g;
        rst = 1'b1; wr_hold = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0; req_lock = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i + 1), 32'h100 + 32'(i), 1'b0);
        #2;
        // Reset state: outputs zero, grants forced low.
        check("rst_ready", 64'(req_ready), 64'h0);
        check_wr("rst", 1'b0, 3'd0, 32'h0, 3'd0);
        check("rst_locked", 64'(locked), 64'h0);
        rst = 1'b0;
        #1;

        // All valid: round robin 0,1,2,3,0.
        for (int c = 0; c < 5; c++) begin
            g = c % 4;
            exp_g = 4'b0001 << g;
            check($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(exp_g));
            tick();
            check_wr($sformatf("rr%0d", c), 1'b1, 3'(g + 1), 32'h100 + 32'(g), 3'(g));
        end
        req_valid = '0;
        #1;
        check("idle_ready", 64'(req_ready), 64'h0);
        tick();
        check("idle_en", 64'(wr_enable), 64'h0);

        // req2 alone writes PC.
        set_req(2, 1'b1, 3'd6, 32'h0000_0040, 1'b0);
        #1;
        check("pc_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check_wr("pc", 1'b1, 3'd6, 32'h40, 3'd2);

        // req1 writes ZR: granted but no strobe; next grant is req2.
        set_req(1, 1'b1, 3'd0, 32'hFFFF_FFFF, 1'b0);
        #1;
        check("zr_ready", 64'(req_ready), 64'b0010);
        tick();
        check_wr("zr", 1'b0, 3'd0, 32'hFFFF_FFFF, 3'd1);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i + 1), 32'h100 + 32'(i), 1'b0);
        #1;
        check("after_zr", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;

        // Hold for 3 cycles with req0 valid, then release.
        wr_hold = 1'b1;
        set_req(0, 1'b1, 3'd3, 32'hA5A5_0003, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("hold_ready%0d", c), 64'(req_ready), 64'h0);
            tick();
            check($sformatf("hold_en%0d", c), 64'(wr_enable), 64'h0);
        end
        wr_hold = 1'b0;
        #1;
        check("unhold_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check_wr("unhold", 1'b1, 3'd3, 32'hA5A5_0003, 3'd0);

`ifdef SRF_ARB_LOCK_EN
        // Lock: req1 writes LR (lock), idles 2 cycles, writes PC (release).
        set_req(0, 1'b1, 3'd1, 32'h1111_0000, 1'b0);
        set_req(3, 1'b1, 3'd2, 32'h3333_0000, 1'b0);
        set_req(1, 1'b1, 3'd5, 32'h0000_1234, 1'b1);
        #1;
        check("lk_lr_ready", 64'(req_ready), 64'b0010);
        tick();
        check_wr("lk_lr", 1'b1, 3'd5, 32'h1234, 3'd1);
        check("lk_locked", 64'(locked), 64'h1);
        req_valid[1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("lk_idle%0d", c), 64'(req_ready), 64'h0);
            tick();
            check($sformatf("lk_idle_en%0d", c), 64'(wr_enable), 64'h0);
            check($sformatf("lk_still%0d", c), 64'(locked), 64'h1);
        end
        set_req(1, 1'b1, 3'd6, 32'h0000_2000, 1'b0);
        #1;
        check("lk_pc_ready", 64'(req_ready), 64'b0010);
        tick();
        check_wr("lk_pc", 1'b1, 3'd6, 32'h2000, 3'd1);
        check("lk_unlocked", 64'(locked), 64'h0);
        req_valid[1] = 1'b0;
        #1;
        check("lk_next", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
`endif

        // Reset while a write is pending (and locked when the feature exists).
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'(i + 1), 32'h200 + 32'(i), 1'b1);
`ifdef SRF_ARB_LOCK_EN
        g = 0;
`else
        g = 1;
`endif
        #1;
        exp_g = 4'b0001 << g;
        check("pre_rst_ready", 64'(req_ready), 64'(exp_g));
        tick();
        check_wr("pre_rst", 1'b1, 3'(g + 1), 32'h200 + 32'(g), 3'(g));
`ifdef SRF_ARB_LOCK_EN
        check("pre_rst_lock", 64'(locked), 64'h1);
`endif
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_en", 64'(wr_enable), 64'h0);
        check("mid_rst_lock", 64'(locked), 64'h0);
        check("mid_rst_ready", 64'(req_ready), 64'h0);
        check("mid_rst_own", 64'(owner), 64'h0);
        rst = 1'b0;
        req_lock = '0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b0001);
        tick();
        check_wr("post_rst", 1'b1, 3'd1, 32'h200, 3'd0);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
